// File: rtl/mem_pkg.sv
// Shared definitions for the reg_file_memory slice.
//   state_t   : controller states (idle / clear sweep)
//   DEF_*     : default geometry
//   cnt_w()   : width needed to hold an occupancy count of 0..depth
package mem_pkg;

  typedef enum logic {
    ST_IDLE,
    ST_CLEAR
  } state_t;

  localparam int DEF_DATA_W = 8;
  localparam int DEF_DEPTH  = 4;

  function automatic int cnt_w(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/mem_entry.sv
// One storage word plus its valid flag.
//   clk, rst_n : clock, async active-low reset (word and flag to 0)
//   wr_en      : load d and mark valid
//   clr        : zero the word and mark invalid (wins over wr_en)
//   d          : write data
//   q, vld     : stored word and valid flag
module mem_entry
  import mem_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wr_en,
  input  logic              clr,
  input  logic [DATA_W-1:0] d,
  output logic [DATA_W-1:0] q,
  output logic              vld
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q   <= '0;
      vld <= 1'b0;
    end else if (clr) begin
      q   <= '0;
      vld <= 1'b0;
    end else if (wr_en) begin
      q   <= d;
      vld <= 1'b1;
    end
  end

endmodule

// File: rtl/reg_file_memory.sv
// DEPTH x DATA_W register file with a synchronous write port, a registered
// read port, per-entry valid flags, an occupancy count and a clear sequencer
// that zeroes one entry per cycle.
//   clk, rst_n          : clock, async active-low reset
//   wr_en/addr/data     : write request
//   rd_en/addr          : read request; result one cycle later
//   clear               : start the clear sweep (ignored while sweeping)
//   rd_data/valid/hit   : registered read result
//   wr_ack / wr_err     : one-cycle pulse, previous write committed / dropped
//   busy                : clear sweep in progress
//   count               : number of valid entries
module reg_file_memory
  import mem_pkg::*;
#(
  parameter  int DATA_W = DEF_DATA_W,
  parameter  int DEPTH  = DEF_DEPTH,
  localparam int ADDR_W = $clog2(DEPTH),
  localparam int CNT_W  = cnt_w(DEPTH)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              rd_en,
  input  logic [ADDR_W-1:0] rd_addr,
  input  logic              clear,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_valid,
  output logic              rd_hit,
  output logic              wr_ack,
  output logic              wr_err,
  output logic              busy,
  output logic [CNT_W-1:0]  count
);

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   clr_idx_q;
  logic [CNT_W-1:0]    count_q;
  logic [DATA_W-1:0]   q_arr [DEPTH];
  logic [DEPTH-1:0]    vld_arr;

  logic                busy_w;
  logic                wr_in_range, rd_in_range;
  logic                wr_commit;
  logic                last_idx;
  logic [DATA_W-1:0]   rd_word;
  logic                rd_vld_sel, wr_vld_sel, clr_vld_sel;

  assign busy_w      = (state_q == ST_CLEAR);
  assign wr_in_range = (32'(wr_addr) < DEPTH);
  assign rd_in_range = (32'(rd_addr) < DEPTH);
  // A clear request in the same cycle pre-empts the write.
  assign wr_commit   = wr_en && !busy_w && !clear && wr_in_range;
  assign last_idx    = (clr_idx_q == ADDR_W'(DEPTH - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (clear)    state_d = ST_CLEAR;
      ST_CLEAR: if (last_idx) state_d = ST_IDLE;
      default:                state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                clr_idx_q <= '0;
    else if (state_q == ST_IDLE) clr_idx_q <= '0;
    else                       clr_idx_q <= clr_idx_q + ADDR_W'(1);
  end

  for (genvar i = 0; i < DEPTH; i++) begin : g_entry
    mem_entry #(.DATA_W(DATA_W)) u_entry (
      .clk   (clk),
      .rst_n (rst_n),
      .wr_en (wr_commit && (wr_addr == ADDR_W'(i))),
      .clr   (busy_w && (clr_idx_q == ADDR_W'(i))),
      .d     (wr_data),
      .q     (q_arr[i]),
      .vld   (vld_arr[i])
    );
  end

  // Compare-based selection keeps out-of-range addresses (non power-of-two
  // DEPTH) from ever indexing past the array.
  always_comb begin
    rd_word     = '0;
    rd_vld_sel  = 1'b0;
    wr_vld_sel  = 1'b0;
    clr_vld_sel = 1'b0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      if (32'(rd_addr) == i) begin
        rd_word    = q_arr[i];
        rd_vld_sel = vld_arr[i];
      end
      if (32'(wr_addr) == i)   wr_vld_sel  = vld_arr[i];
      if (32'(clr_idx_q) == i) clr_vld_sel = vld_arr[i];
    end
  end

  // Writes are never committed during a sweep, so increment and decrement
  // cannot coincide.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                        count_q <= '0;
    else if (wr_commit && !wr_vld_sel) count_q <= count_q + CNT_W'(1);
    else if (busy_w && clr_vld_sel)    count_q <= count_q - CNT_W'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_data  <= '0;
      rd_valid <= 1'b0;
      rd_hit   <= 1'b0;
      wr_ack   <= 1'b0;
      wr_err   <= 1'b0;
    end else begin
      wr_ack   <= wr_commit;
      wr_err   <= wr_en && !wr_commit;
      rd_valid <= rd_en;
      if (rd_en) begin
        if (busy_w || !rd_in_range) begin
          rd_data <= '0;
          rd_hit  <= 1'b0;
        end else if (wr_commit && (wr_addr == rd_addr)) begin
          rd_data <= wr_data;
          rd_hit  <= 1'b1;
        end else if (rd_vld_sel) begin
          rd_data <= rd_word;
          rd_hit  <= 1'b1;
        end else begin
          rd_data <= '0;
          rd_hit  <= 1'b0;
        end
      end else begin
        rd_hit <= 1'b0;
      end
    end
  end

  assign busy  = busy_w;
  assign count = count_q;

endmodule

// File: tb/tb_reg_file_memory.sv
module tb_reg_file_memory;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n, rst5_n;

  // DEPTH=4 instance
  logic       wr_en, rd_en, clear;
  logic [1:0] wr_addr, rd_addr;
  logic [7:0] wr_data, rd_data;
  logic       rd_valid, rd_hit, wr_ack, wr_err, busy;
  logic [2:0] count;

  // DEPTH=5 instance
  logic       w5_en, r5_en, c5;
  logic [2:0] w5_addr, r5_addr;
  logic [7:0] w5_data, r5_data;
  logic       r5_valid, r5_hit, w5_ack, w5_err, b5;
  logic [2:0] cnt5;

  reg_file_memory #(.DATA_W(8), .DEPTH(4)) u_dut (
    .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_addr(wr_addr),
    .wr_data(wr_data), .rd_en(rd_en), .rd_addr(rd_addr), .clear(clear),
    .rd_data(rd_data), .rd_valid(rd_valid), .rd_hit(rd_hit),
    .wr_ack(wr_ack), .wr_err(wr_err), .busy(busy), .count(count)
  );

  reg_file_memory #(.DATA_W(8), .DEPTH(5)) u_dut5 (
    .clk(clk), .rst_n(rst5_n), .wr_en(w5_en), .wr_addr(w5_addr),
    .wr_data(w5_data), .rd_en(r5_en), .rd_addr(r5_addr), .clear(c5),
    .rd_data(r5_data), .rd_valid(r5_valid), .rd_hit(r5_hit),
    .wr_ack(w5_ack), .wr_err(w5_err), .busy(b5), .count(cnt5)
  );

  typedef struct {
    logic       we;
    logic [1:0] wa;
    logic [7:0] wd;
    logic       re;
    logic [1:0] ra;
    logic       clr;
    logic       rv;
    logic [7:0] rd;
    logic       hit;
    logic       ack;
    logic       err;
    logic       bsy;
    logic [2:0] cnt;
  } vec_t;

  int checks = 0;
  int errors = 0;
  vec_t vecs[24];

  function automatic vec_t mk(logic we, logic [1:0] wa, logic [7:0] wd,
                              logic re, logic [1:0] ra, logic clr,
                              logic rv, logic [7:0] rd, logic hit,
                              logic ack, logic err, logic bsy, logic [2:0] cnt);
    vec_t v;
    v.we = we; v.wa = wa; v.wd = wd; v.re = re; v.ra = ra; v.clr = clr;
    v.rv = rv; v.rd = rd; v.hit = hit; v.ack = ack; v.err = err;
    v.bsy = bsy; v.cnt = cnt;
    return v;
  endfunction

  task automatic chk(input string name, input int idx,
                     input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s[%0d]: got 0x%0h expected 0x%0h", name, idx, act, exp);
    end
  endtask

  initial begin
    //            we wa  wd     re ra clr  rv rd     hit ack err bsy cnt
    vecs[0]  = mk(0, 0, 8'h00, 1, 2, 0,   1, 8'h00, 0,  0,  0,  0,  0); // read empty
    vecs[1]  = mk(1, 0, 8'hA5, 0, 0, 0,   0, 8'h00, 0,  1,  0,  0,  1);
    vecs[2]  = mk(1, 3, 8'h3C, 0, 0, 0,   0, 8'h00, 0,  1,  0,  0,  2);
    vecs[3]  = mk(0, 0, 8'h00, 1, 3, 0,   1, 8'h3C, 1,  0,  0,  0,  2);
    vecs[4]  = mk(1, 3, 8'h11, 0, 0, 0,   0, 8'h3C, 0,  1,  0,  0,  2); // rewrite, hold
    vecs[5]  = mk(1, 1, 8'h77, 1, 1, 0,   1, 8'h77, 1,  1,  0,  0,  3); // write-first
    vecs[6]  = mk(0, 0, 8'h00, 1, 3, 0,   1, 8'h11, 1,  0,  0,  0,  3);
    vecs[7]  = mk(1, 2, 8'h22, 0, 0, 0,   0, 8'h11, 0,  1,  0,  0,  4); // full
    vecs[8]  = mk(0, 0, 8'h00, 0, 0, 1,   0, 8'h11, 0,  0,  0,  1,  4); // clear
    vecs[9]  = mk(1, 0, 8'hFF, 0, 0, 0,   0, 8'h11, 0,  0,  1,  1,  3); // write while busy
    vecs[10] = mk(0, 0, 8'h00, 0, 0, 0,   0, 8'h11, 0,  0,  0,  1,  2);
    vecs[11] = mk(0, 0, 8'h00, 1, 0, 1,   1, 8'h00, 0,  0,  0,  1,  1); // re-clear ignored
    vecs[12] = mk(0, 0, 8'h00, 0, 0, 0,   0, 8'h00, 0,  0,  0,  0,  0); // busy falls
    vecs[13] = mk(0, 0, 8'h00, 1, 0, 0,   1, 8'h00, 0,  0,  0,  0,  0);
    vecs[14] = mk(0, 0, 8'h00, 1, 1, 0,   1, 8'h00, 0,  0,  0,  0,  0);
    vecs[15] = mk(0, 0, 8'h00, 1, 2, 0,   1, 8'h00, 0,  0,  0,  0,  0);
    vecs[16] = mk(0, 0, 8'h00, 1, 3, 0,   1, 8'h00, 0,  0,  0,  0,  0);
    vecs[17] = mk(1, 2, 8'h5A, 0, 0, 0,   0, 8'h00, 0,  1,  0,  0,  1);
    vecs[18] = mk(1, 1, 8'h66, 0, 0, 1,   0, 8'h00, 0,  0,  1,  1,  1); // clear beats write
    vecs[19] = mk(0, 0, 8'h00, 1, 1, 0,   1, 8'h00, 0,  0,  0,  1,  1);
    vecs[20] = mk(0, 0, 8'h00, 0, 0, 0,   0, 8'h00, 0,  0,  0,  1,  1);
    vecs[21] = mk(0, 0, 8'h00, 0, 0, 0,   0, 8'h00, 0,  0,  0,  1,  0);
    vecs[22] = mk(0, 0, 8'h00, 0, 0, 0,   0, 8'h00, 0,  0,  0,  0,  0);
    vecs[23] = mk(0, 0, 8'h00, 1, 1, 0,   1, 8'h00, 0,  0,  0,  0,  0);

    rst_n = 1'b0; rst5_n = 1'b0;
    wr_en = 0; wr_addr = '0; wr_data = '0; rd_en = 0; rd_addr = '0; clear = 0;
    w5_en = 0; w5_addr = '0; w5_data = '0; r5_en = 0; r5_addr = '0; c5 = 0;
    #12;
    chk("rst_rd_valid", 0, 32'(rd_valid), 0);
    chk("rst_busy",     0, 32'(busy),     0);
    chk("rst_count",    0, 32'(count),    0);
    chk("rst_wr_ack",   0, 32'(wr_ack),   0);
    #2;
    rst_n = 1'b1; rst5_n = 1'b1;

    foreach (vecs[i]) begin
      @(negedge clk);
      wr_en = vecs[i].we; wr_addr = vecs[i].wa; wr_data = vecs[i].wd;
      rd_en = vecs[i].re; rd_addr = vecs[i].ra; clear = vecs[i].clr;
      @(posedge clk); #1;
      chk("rd_valid", i, 32'(rd_valid), 32'(vecs[i].rv));
      chk("rd_data",  i, 32'(rd_data),  32'(vecs[i].rd));
      chk("rd_hit",   i, 32'(rd_hit),   32'(vecs[i].hit));
      chk("wr_ack",   i, 32'(wr_ack),   32'(vecs[i].ack));
      chk("wr_err",   i, 32'(wr_err),   32'(vecs[i].err));
      chk("busy",     i, 32'(busy),     32'(vecs[i].bsy));
      chk("count",    i, 32'(count),    32'(vecs[i].cnt));
    end
    @(negedge clk);
    wr_en = 0; rd_en = 0; clear = 0;

    // DEPTH=5: out-of-range write
    w5_en = 1; w5_addr = 3'd7; w5_data = 8'h99;
    @(posedge clk); #1;
    chk("d5_oor_err", 0, 32'(w5_err), 1);
    chk("d5_oor_ack", 0, 32'(w5_ack), 0);
    chk("d5_oor_cnt", 0, 32'(cnt5),   0);
    @(negedge clk);
    w5_addr = 3'd4; w5_data = 8'h12;
    @(posedge clk); #1;
    chk("d5_wr4_ack", 0, 32'(w5_ack), 1);
    chk("d5_wr4_cnt", 0, 32'(cnt5),   1);
    @(negedge clk);
    w5_en = 0; r5_en = 1; r5_addr = 3'd4;
    @(posedge clk); #1;
    chk("d5_rd4_data", 0, 32'(r5_data), 32'h12);
    chk("d5_rd4_hit",  0, 32'(r5_hit),  1);
    @(negedge clk);
    r5_addr = 3'd7;
    @(posedge clk); #1;
    chk("d5_rd7_valid", 0, 32'(r5_valid), 1);
    chk("d5_rd7_data",  0, 32'(r5_data),  0);
    chk("d5_rd7_hit",   0, 32'(r5_hit),   0);
    @(negedge clk);
    r5_en = 0; w5_en = 1; w5_addr = 3'd0; w5_data = 8'h34;
    @(posedge clk); #1;
    chk("d5_wr0_cnt", 0, 32'(cnt5), 2);
    @(negedge clk);
    w5_en = 0; c5 = 1;
    @(posedge clk); #1;
    chk("d5_clr_busy", 0, 32'(b5),   1);
    chk("d5_clr_cnt",  0, 32'(cnt5), 2);
    @(negedge clk);
    c5 = 0;
    @(posedge clk); #1;
    chk("d5_clr2_cnt", 0, 32'(cnt5), 1);
    // Reset in the middle of the sweep, checked before the next edge.
    #2 rst5_n = 1'b0;
    #1;
    chk("d5_rst_busy",  0, 32'(b5),       0);
    chk("d5_rst_cnt",   0, 32'(cnt5),     0);
    chk("d5_rst_valid", 0, 32'(r5_valid), 0);
    #2 rst5_n = 1'b1;
    @(negedge clk);
    r5_en = 1; r5_addr = 3'd4;
    @(posedge clk); #1;
    chk("d5_post_valid", 0, 32'(r5_valid), 1);
    chk("d5_post_data",  0, 32'(r5_data),  0);
    chk("d5_post_hit",   0, 32'(r5_hit),   0);
    chk("d5_post_busy",  0, 32'(b5),       0);
    @(negedge clk);
    r5_en = 0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/reg_file_memory.md
Name: reg_file_memory

Overview:
Parametrised, clocked successor to the 4-entry latch memory. Holds DEPTH words of DATA_W bits, with one synchronous write port and one registered read port. Tracks a per-entry valid bit and an occupancy count, and provides a multi-cycle hardware clear sequencer. Sits between the switch/button input logic and the seven-segment/LED display path on the lab board top level.

Parameters:
DATA_W, 8, width of each stored word
DEPTH, 4, number of entries; any value ≥2, need not be a power of two
ADDR_W, $clog2(DEPTH), address width (derived; not overridden)

Ports:
clk  in  1  system clock, all state updates on rising edge
rst_n  in  1  asynchronous active-low reset
wr_en  in  1  write request (store strobe), sampled each clk
wr_addr  in  ADDR_W  write address
wr_data  in  DATA_W  write data
rd_en  in  1  read request
rd_addr  in  ADDR_W  read address
clear  in  1  start clear sequence (single-cycle pulse or level; edge not required)
rd_data  out  DATA_W  registered read data
rd_valid  out  1  one-cycle pulse: rd_data updated this cycle
rd_hit  out  1  entry read was valid (qualified by rd_valid)
wr_ack  out  1  one-cycle pulse: previous-cycle write committed
wr_err  out  1  one-cycle pulse: previous-cycle write dropped
busy  out  1  clear sequence in progress
count  out  $clog2(DEPTH+1)  number of valid entries

Behaviour:
- Reset (rst_n low, async): all memory words 0, all valid bits 0, FSM to IDLE. rd_data=0, rd_valid=0, rd_hit=0, wr_ack=0, wr_err=0, busy=0, count=0.
- FSM states:
  - IDLE: normal operation.
  - CLEAR: sweep index 0..DEPTH-1, one entry per cycle.
- IDLE→CLEAR: on clear=1; busy goes high next cycle.
- CLEAR→IDLE: after the entry at index DEPTH-1 is zeroed. The sweep takes exactly DEPTH cycles; busy falls the cycle after the last entry is cleared.
- Clear sweep: each swept entry gets data=0 and valid=0; count decrements for each previously valid entry. clear asserted while in CLEAR is ignored (no restart).
- Write, IDLE, wr_en=1, wr_addr<DEPTH, clear=0:
  - mem[wr_addr]<=wr_data and valid set.
  - wr_ack=1 next cycle.
  - count increments only if the entry was previously invalid.
- Write dropped (mem unchanged, wr_err=1 next cycle) when any of:
  - wr_en while busy;
  - wr_en together with clear in IDLE (clear wins);
  - wr_addr ≥ DEPTH.
- Read: rd_en=1 → the next cycle shows rd_valid=1, rd_data=mem[rd_addr], rd_hit=valid[rd_addr].
  - rd_data holds its value when rd_en=0.
  - Invalid entry, rd_addr ≥ DEPTH, or a read while busy: rd_data=0, rd_hit=0, rd_valid still 1.
- Same-cycle read and write to the same address: write-first. rd_data returns wr_data and rd_hit=1 if the write commits.
- Reset asserted mid-clear or mid-write: immediate return to reset state. No partial state persists.
- count never exceeds DEPTH and never underflows.

Decomposition:
- Shared package mem_pkg:
  - state enum (ST_IDLE, ST_CLEAR);
  - default DATA_W/DEPTH constants;
  - count-width function.
- One natural sub-module: mem_entry, a single DATA_W register plus valid bit, with ports wr_en, clr, d, q, vld and async active-low reset. It is instantiated DEPTH times by a generate loop, replacing the old latch byte cell.

Test Plan:
- Reset then read addr 2 → rd_valid=1, rd_data=0x00, rd_hit=0, count=0.
- Write 0xA5@0, 0x3C@3 → wr_ack pulses twice, count=2. Read 3 → rd_data=0x3C, rd_hit=1. Rewrite 0x11@3 → count stays 2.
- Same-cycle write 0x77@1 and read 1 → next cycle rd_data=0x77, rd_hit=1, count=3.
- Fill all 4 entries, pulse clear → busy=1 for 4 cycles. Write 0xFF@0 during busy → wr_err=1, no change. After busy falls, count=0 and all reads give rd_hit=0.
- Clear and wr_en same cycle in IDLE → wr_err=1, clear sequence runs.
- DEPTH=5 instance: write addr 7 → wr_err=1. Assert rst_n=0 at cycle 2 of a clear → busy=0 immediately, count=0.
